// File: rtl/tick_counter_pkg.sv
// Package: tick_counter_pkg
// Shared encodings for the multi-channel tick counter:
//   - config register select codes (cfg_sel)
//   - bit positions inside the CTRL word
//   - per-channel state encoding
package tick_counter_pkg;

    // cfg_sel encodings; 2'd3 is reserved and ignored
    localparam logic [1:0] CFG_CTRL  = 2'd0;
    localparam logic [1:0] CFG_LIMIT = 2'd1;
    localparam logic [1:0] CFG_LOAD  = 2'd2;

    // CTRL word layout: {oneshot, down, enable}
    localparam int CTRL_W       = 3;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_DOWN    = 1;
    localparam int CTRL_ONESHOT = 2;

    // Per-channel state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_e;

endpackage

// File: rtl/tick_channel.sv
// Module: tick_channel
// One counter channel: state machine, count, limit, direction/one-shot mode,
// wrap pulse and sticky done flag. All outputs come straight from flops.
// Ports:
//   clock, resetb          clock / async active-low reset
//   tick                   prescaler tick (advance enable)
//   cfg_we                 config write already decoded for this channel
//   cfg_sel, cfg_wdata     register select / write data
//   count                  current count
//   wrap                   one-cycle pulse on wrap or terminal event
//   done                   sticky, set when a one-shot run finishes
module tick_channel
    import tick_counter_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             tick,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_sel,
    input  logic [CNT_W-1:0] cfg_wdata,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    ch_state_e        state_r, state_s;
    logic             down_r, down_s;
    logic             oneshot_r, oneshot_s;
    logic [CNT_W-1:0] limit_r, limit_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic             wrap_r, wrap_s;
    logic             done_r, done_s;
    logic [CTRL_W-1:0] ctrl_wr_s;

    // LOAD never places the count above the current limit
    function automatic logic [CNT_W-1:0] clamp_to_limit(
        input logic [CNT_W-1:0] value,
        input logic [CNT_W-1:0] lim
    );
        if (value > lim) begin
            return lim;
        end else begin
            return value;
        end
    endfunction

    // Next-state logic: a config write takes priority over a coincident tick
    always_comb begin
        state_s   = state_r;
        down_s    = down_r;
        oneshot_s = oneshot_r;
        limit_s   = limit_r;
        count_s   = count_r;
        wrap_s    = 1'b0;
        done_s    = done_r;
        // CTRL fits in 3 bits; narrower data words are zero-extended
        ctrl_wr_s = CTRL_W'(cfg_wdata);

        if (cfg_we) begin
            case (cfg_sel)
                CFG_CTRL: begin
                    down_s    = ctrl_wr_s[CTRL_DOWN];
                    oneshot_s = ctrl_wr_s[CTRL_ONESHOT];
                    done_s    = 1'b0;
                    if (ctrl_wr_s[CTRL_EN]) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                CFG_LIMIT: limit_s = cfg_wdata;
                CFG_LOAD:  count_s = clamp_to_limit(cfg_wdata, limit_r);
                default: begin
                    // reserved select: write ignored
                    count_s = count_r;
                end
            endcase
        end else if (tick && (state_r == ST_RUN)) begin
            if (!down_r) begin
                if (count_r >= limit_r) begin
                    wrap_s = 1'b1;
                    if (oneshot_r) begin
                        count_s = limit_r;
                        done_s  = 1'b1;
                        state_s = ST_DONE;
                    end else begin
                        count_s = CNT_ZERO;
                    end
                end else begin
                    count_s = count_r + CNT_ONE;
                end
            end else begin
                if (count_r == CNT_ZERO) begin
                    wrap_s = 1'b1;
                    if (oneshot_r) begin
                        count_s = CNT_ZERO;
                        done_s  = 1'b1;
                        state_s = ST_DONE;
                    end else begin
                        count_s = limit_r;
                    end
                end else if (count_r > limit_r) begin
                    // limit lowered below the count: snap down without a wrap
                    count_s = limit_r;
                end else begin
                    count_s = count_r - CNT_ONE;
                end
            end
        end else begin
            state_s = state_r;
        end
    end

    // Channel state registers
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_r   <= ST_IDLE;
            down_r    <= 1'b0;
            oneshot_r <= 1'b0;
            limit_r   <= {CNT_W{1'b1}};
            count_r   <= CNT_ZERO;
            wrap_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            down_r    <= down_s;
            oneshot_r <= oneshot_s;
            limit_r   <= limit_s;
            count_r   <= count_s;
            wrap_r    <= wrap_s;
            done_r    <= done_s;
        end
    end

    assign count = count_r;
    assign wrap  = wrap_r;
    assign done  = done_r;

endmodule

// File: rtl/multi_channel_tick_counter.sv
// Module: multi_channel_tick_counter
// Shared prescaler producing a periodic tick, feeding NUM_CH independent
// programmable counters (tick_channel). Config writes are steered to one
// channel by cfg_ch; an out-of-range channel makes the write a no-op.
// Ports:
//   clock, resetb               user clock / async active-low reset
//   run_i                       global run (0 freezes the prescaler)
//   cfg_we, cfg_ch, cfg_sel,
//   cfg_wdata                   config write port
//   tick_o                      one-cycle pulse per prescaler period
//   count_o                     packed channel counts, ch i at [i*CNT_W +: CNT_W]
//   wrap_o                      per-channel wrap / terminal pulse
//   done_o                      per-channel sticky one-shot done
module multi_channel_tick_counter
    import tick_counter_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 8,
    parameter int TICK_DIV = 40_000_000,
    parameter int CH_AW    = 2
) (
    input  logic                    clock,
    input  logic                    resetb,
    input  logic                    run_i,
    input  logic                    cfg_we,
    input  logic [CH_AW-1:0]        cfg_ch,
    input  logic [1:0]              cfg_sel,
    input  logic [CNT_W-1:0]        cfg_wdata,
    output logic                    tick_o,
    output logic [NUM_CH*CNT_W-1:0] count_o,
    output logic [NUM_CH-1:0]       wrap_o,
    output logic [NUM_CH-1:0]       done_o
);

    localparam int              PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1'b1);

    logic [PS_W-1:0] ps_r;
    logic            tick_r;

    // Prescaler: tick_r rises the cycle after ps_r sits at its last value;
    // with TICK_DIV=1 ps_r is permanently at its last value, so tick stays high
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            ps_r   <= {PS_W{1'b0}};
            tick_r <= 1'b0;
        end else if (run_i) begin
            if (ps_r == PS_LAST) begin
                ps_r <= {PS_W{1'b0}};
            end else begin
                ps_r <= ps_r + PS_ONE;
            end
            tick_r <= (ps_r == PS_LAST);
        end else begin
            ps_r   <= ps_r;
            tick_r <= 1'b0;
        end
    end

    assign tick_o = tick_r;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_we_s;

        assign ch_we_s = cfg_we && (cfg_ch == CH_AW'(i));

        tick_channel #(
            .CNT_W (CNT_W)
        ) u_channel (
            .clock     (clock),
            .resetb    (resetb),
            .tick      (tick_r),
            .cfg_we    (ch_we_s),
            .cfg_sel   (cfg_sel),
            .cfg_wdata (cfg_wdata),
            .count     (count_o[i*CNT_W +: CNT_W]),
            .wrap      (wrap_o[i]),
            .done      (done_o[i])
        );
    end

endmodule

// File: tb/tb_multi_channel_tick_counter.sv
module tb_multi_channel_tick_counter;
    import tick_counter_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic resetb;

    // main instance: 4 channels x 8 bits
    logic        run_m, cfg_we_m;
    logic [1:0]  cfg_ch_m, cfg_sel_m;
    logic [7:0]  cfg_wdata_m;
    logic        tick_m;
    logic [31:0] count_m;
    logic [3:0]  wrap_m, done_m;

    // legacy instance: 1 channel x 2 bits
    logic        run_l, cfg_we_l;
    logic [0:0]  cfg_ch_l;
    logic [1:0]  cfg_sel_l;
    logic [1:0]  cfg_wdata_l;
    logic        tick_l;
    logic [1:0]  count_l;
    logic [0:0]  wrap_l, done_l;

    multi_channel_tick_counter #(
        .NUM_CH(4), .CNT_W(8), .TICK_DIV(4), .CH_AW(2)
    ) dut_main (
        .clock(clock), .resetb(resetb), .run_i(run_m),
        .cfg_we(cfg_we_m), .cfg_ch(cfg_ch_m), .cfg_sel(cfg_sel_m), .cfg_wdata(cfg_wdata_m),
        .tick_o(tick_m), .count_o(count_m), .wrap_o(wrap_m), .done_o(done_m)
    );

    multi_channel_tick_counter #(
        .NUM_CH(1), .CNT_W(2), .TICK_DIV(4), .CH_AW(1)
    ) dut_leg (
        .clock(clock), .resetb(resetb), .run_i(run_l),
        .cfg_we(cfg_we_l), .cfg_ch(cfg_ch_l), .cfg_sel(cfg_sel_l), .cfg_wdata(cfg_wdata_l),
        .tick_o(tick_l), .count_o(count_l), .wrap_o(wrap_l), .done_o(done_l)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int    stamp;
        bit    is_tick;
        int    dut;
        int    ch;
        int    cnt;
        bit    wrap;
        bit    done;
        string name;
    } exp_t;

    exp_t sb_q[$];
    exp_t async_q[$];
    event async_ev;

    function automatic void check_item(input exp_t e);
        logic       act_t, act_w, act_d;
        logic [7:0] act_cnt;
        n_checks++;
        if (e.is_tick) begin
            act_t = (e.dut == 1) ? tick_l : tick_m;
            if (act_t === e.wrap) n_pass++;
            else $display("FAIL %s: tick_o=%b required %b (cycle %0d)", e.name, act_t, e.wrap, cyc);
        end else begin
            if (e.dut == 1) begin
                act_cnt = {6'b000000, count_l};
                act_w   = wrap_l[0];
                act_d   = done_l[0];
            end else begin
                act_cnt = count_m[e.ch*8 +: 8];
                act_w   = wrap_m[e.ch];
                act_d   = done_m[e.ch];
            end
            if (act_cnt === 8'(e.cnt) && act_w === e.wrap && act_d === e.done) n_pass++;
            else $display("FAIL %s: dut%0d ch%0d count=%0d wrap=%b done=%b, required count=%0d wrap=%b done=%b (cycle %0d)",
                          e.name, e.dut, e.ch, act_cnt, act_w, act_d, e.cnt, e.wrap, e.done, cyc);
        end
    endfunction

    // Scoreboard monitor: compare every expectation due at this sample point
    always @(negedge clock) begin
        while (sb_q.size() > 0 && sb_q[0].stamp <= cyc) check_item(sb_q.pop_front());
    end

    // Monitor for checks that must land between clock edges
    always @(async_ev) begin
        while (async_q.size() > 0) check_item(async_q.pop_front());
    end

    task automatic exp_ch(input int dly, input int dut, input int ch, input int cnt,
                          input bit w, input bit d, input string name);
        exp_t e;
        e.stamp = cyc + dly; e.is_tick = 1'b0; e.dut = dut; e.ch = ch;
        e.cnt = cnt; e.wrap = w; e.done = d; e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic exp_tk(input int dly, input int dut, input bit t, input string name);
        exp_t e;
        e.stamp = cyc + dly; e.is_tick = 1'b1; e.dut = dut; e.ch = 0;
        e.cnt = 0; e.wrap = t; e.done = 1'b0; e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic exp_async(input bit is_tick, input int dut, input int ch, input string name);
        exp_t e;
        e.stamp = cyc; e.is_tick = is_tick; e.dut = dut; e.ch = ch;
        e.cnt = 0; e.wrap = 1'b0; e.done = 1'b0; e.name = name;
        async_q.push_back(e);
    endtask

    task automatic cfg_m(input int ch, input logic [1:0] sel, input logic [7:0] d);
        cfg_ch_m = 2'(ch); cfg_sel_m = sel; cfg_wdata_m = d; cfg_we_m = 1'b1;
        @(negedge clock);
        cfg_we_m = 1'b0;
    endtask

    task automatic cfg_l(input logic [0:0] ch, input logic [1:0] sel, input logic [1:0] d);
        cfg_ch_l = ch; cfg_sel_l = sel; cfg_wdata_l = d; cfg_we_l = 1'b1;
        @(negedge clock);
        cfg_we_l = 1'b0;
    endtask

    task automatic wait_tick(input bit leg);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (((leg ? tick_l : tick_m) !== 1'b1) && n < 20);
        if ((leg ? tick_l : tick_m) !== 1'b1) begin
            n_checks++;
            $display("FAIL tick_timeout: tick_o=%b required 1 within 20 cycles", leg ? tick_l : tick_m);
        end
    endtask

    task automatic stop_run();
        run_m = 1'b0;
        run_l = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        int guard;
        resetb = 1'b0;
        run_m = 1'b0; cfg_we_m = 1'b0; cfg_ch_m = 2'd0; cfg_sel_m = 2'd0; cfg_wdata_m = 8'd0;
        run_l = 1'b0; cfg_we_l = 1'b0; cfg_ch_l = 1'b0; cfg_sel_l = 2'd0; cfg_wdata_l = 2'd0;

        // reset state
        repeat (3) @(negedge clock);
        for (int c = 0; c < 4; c++) exp_ch(1, 0, c, 0, 1'b0, 1'b0, "reset_main");
        exp_ch(1, 1, 0, 0, 1'b0, 1'b0, "reset_leg");
        exp_tk(1, 0, 1'b0, "reset_tick");
        @(negedge clock);
        resetb = 1'b1;

        // 1: legacy 0,1,2,3,0 sequence
        exp_ch(1, 1, 0, 0, 1'b0, 1'b0, "leg_ctrl");
        cfg_l(1'b0, CFG_CTRL, 2'b01);
        run_l = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            wait_tick(1'b1);
            exp_ch(1, 1, 0, k % 4, (k == 4), 1'b0, "leg_seq");
            exp_ch(2, 1, 0, k % 4, 1'b0, 1'b0, "leg_hold");
        end
        stop_run();
        exp_ch(1, 1, 0, 1, 1'b0, 1'b0, "leg_bad_channel");
        cfg_l(1'b1, CFG_LOAD, 2'd2);

        // 2: down one-shot on ch2
        exp_ch(1, 0, 2, 0, 1'b0, 1'b0, "t2_limit");
        cfg_m(2, CFG_LIMIT, 8'd5);
        exp_ch(1, 0, 2, 5, 1'b0, 1'b0, "t2_load");
        cfg_m(2, CFG_LOAD, 8'd5);
        exp_ch(1, 0, 2, 5, 1'b0, 1'b0, "t2_ctrl");
        cfg_m(2, CFG_CTRL, 8'h07);
        run_m = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            wait_tick(1'b0);
            exp_ch(1, 0, 2, (k <= 5) ? 5 - k : 0, (k == 6), (k >= 6), "t2_down");
            exp_ch(2, 0, 2, (k <= 5) ? 5 - k : 0, 1'b0, (k >= 6), "t2_hold");
        end
        stop_run();
        exp_ch(1, 0, 2, 0, 1'b0, 1'b0, "t2_clear_done");
        cfg_m(2, CFG_CTRL, 8'h01);
        exp_ch(1, 0, 2, 0, 1'b0, 1'b0, "t2_idle");
        cfg_m(2, CFG_CTRL, 8'h00);

        // 3: collision of LOAD with tick
        exp_ch(1, 0, 0, 0, 1'b0, 1'b0, "t3_en0");
        cfg_m(0, CFG_CTRL, 8'h01);
        exp_ch(1, 0, 1, 0, 1'b0, 1'b0, "t3_en1");
        cfg_m(1, CFG_CTRL, 8'h01);
        exp_ch(1, 0, 0, 0, 1'b0, 1'b0, "t3_reserved_sel");
        cfg_m(0, 2'd3, 8'h55);
        run_m = 1'b1;
        wait_tick(1'b0);
        exp_ch(1, 0, 0, 1, 1'b0, 1'b0, "t3_up0");
        exp_ch(1, 0, 1, 1, 1'b0, 1'b0, "t3_up1");
        wait_tick(1'b0);
        exp_ch(1, 0, 0, 2, 1'b0, 1'b0, "t3_collide_other");
        exp_ch(1, 0, 1, 7, 1'b0, 1'b0, "t3_collide_load");
        cfg_m(1, CFG_LOAD, 8'd7);
        wait_tick(1'b0);
        exp_ch(1, 0, 0, 3, 1'b0, 1'b0, "t3_after0");
        exp_ch(1, 0, 1, 8, 1'b0, 1'b0, "t3_after1");
        stop_run();

        // 4: clamp and lowered limit on ch3
        exp_ch(1, 0, 3, 0, 1'b0, 1'b0, "t4_limit6");
        cfg_m(3, CFG_LIMIT, 8'd6);
        exp_ch(1, 0, 3, 6, 1'b0, 1'b0, "t4_clamp");
        cfg_m(3, CFG_LOAD, 8'd9);
        exp_ch(1, 0, 3, 6, 1'b0, 1'b0, "t4_en");
        cfg_m(3, CFG_CTRL, 8'h01);
        exp_ch(1, 0, 3, 6, 1'b0, 1'b0, "t4_limit2_nochange");
        cfg_m(3, CFG_LIMIT, 8'd2);
        run_m = 1'b1;
        wait_tick(1'b0);
        exp_ch(1, 0, 0, 4, 1'b0, 1'b0, "t4_ch0");
        exp_ch(1, 0, 1, 9, 1'b0, 1'b0, "t4_ch1");
        exp_ch(1, 0, 3, 0, 1'b1, 1'b0, "t4_wrap");
        exp_ch(2, 0, 3, 0, 1'b0, 1'b0, "t4_wrap_end");
        stop_run();

        // 6: gating, then limit=0
        for (int i = 1; i <= 10; i++) exp_tk(i, 0, 1'b0, "t6_gate_tick");
        exp_ch(10, 0, 0, 4, 1'b0, 1'b0, "t6_hold0");
        exp_ch(10, 0, 1, 9, 1'b0, 1'b0, "t6_hold1");
        repeat (10) @(negedge clock);
        exp_ch(1, 0, 0, 4, 1'b0, 1'b0, "t6_lim0_nochange");
        cfg_m(0, CFG_LIMIT, 8'd0);
        run_m = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wait_tick(1'b0);
            exp_ch(1, 0, 0, 0, 1'b1, 1'b0, "t6_lim0_wrap");
            exp_ch(2, 0, 0, 0, 1'b0, 1'b0, "t6_lim0_pulse_end");
        end

        // 5: asynchronous reset mid-run
        repeat (3) @(negedge clock);
        #2 resetb = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) exp_async(1'b0, 0, c, "t5_async_main");
        exp_async(1'b0, 1, 0, "t5_async_leg");
        exp_async(1'b1, 0, 0, "t5_async_tick");
        -> async_ev;
        @(negedge clock);
        run_m = 1'b0;
        resetb = 1'b1;
        exp_ch(1, 0, 0, 255, 1'b0, 1'b0, "t5_limit_ones0");
        cfg_m(0, CFG_LOAD, 8'd255);
        exp_ch(1, 0, 3, 200, 1'b0, 1'b0, "t5_limit_ones3");
        cfg_m(3, CFG_LOAD, 8'd200);
        exp_ch(1, 1, 0, 3, 1'b0, 1'b0, "t5_limit_ones_leg");
        cfg_l(1'b0, CFG_LOAD, 2'd3);

        guard = 0;
        while (sb_q.size() > 0 && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            $display("FAIL %s: not sampled, required at cycle %0d", e.name, e.stamp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
